// File: rtl/instruction_fetch_if.sv
// Instruction-memory handshake bus between the fetch stage and instruction memory.
// A single request is outstanding at a time; the address is held until ack.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack fetch,
// holds the fetched word for the decoder and applies jump/branch redirects.
// NOP_INST is presented whenever no valid instruction is held.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       nreset,
    instruction_fetch_if.master        imem,
    input  logic                       stall,
    input  logic                       jmp_taken,
    input  logic [31:0]                jmp_addr,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic                       inst_valid,
    output logic                       fetch_fault
);

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        ISSUE,
        DRAIN,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] drain_addr;   // address of the request still in flight during DRAIN
    logic        active;
    logic        redirect;
    logic        misaligned;

    assign active     = (state == FETCH) || (state == ISSUE) || (state == DRAIN);
    assign redirect   = jmp_taken && active;
    assign misaligned = (jmp_addr[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; redirect takes priority over stall and ack, but a
    // pending memory handshake is always completed (via DRAIN) before HALT.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (jmp_taken) begin
                    if (!imem.imem_ack) begin
                        state_next = DRAIN;
                    end else if (misaligned) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (imem.imem_ack) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (jmp_taken) begin
                    state_next = misaligned ? HALT : FETCH;
                end else if (!stall) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                // fetch_fault here can only come from a misaligned redirect
                // taken while this request was outstanding
                if (imem.imem_ack) begin
                    if (fetch_fault || (jmp_taken && misaligned)) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Memory-side outputs: request while fetching or draining; DRAIN keeps the old address
    always_comb begin
        imem.imem_req  = (state == FETCH) || (state == DRAIN);
        imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
    end

    // PC, held instruction and sticky fault
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            inst        <= NOP_INST;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect) begin
            pc         <= jmp_addr;
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            if (misaligned) begin
                fetch_fault <= 1'b1;
            end
            if ((state == FETCH) && !imem.imem_ack) begin
                drain_addr <= pc;
            end
        end else if ((state == FETCH) && imem.imem_ack) begin
            inst       <= imem.imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + 32'd4;
        end else if ((state == ISSUE) && !stall) begin
            inst       <= NOP_INST;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with RESET_PC=0x100.
// Table of per-cycle vectors followed by hand-written reset/halt sequences.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        nreset;
    logic        stall;
    logic        jmp_taken;
    logic [31:0] jmp_addr;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        fetch_fault;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (32'h0000_0100),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .imem        (bus.master),
        .stall       (stall),
        .jmp_taken   (jmp_taken),
        .jmp_addr    (jmp_addr),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        jmp;
        logic [31:0] jaddr;
        logic        e_req;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic ack, logic [31:0] rdata, logic st, logic jmp, logic [31:0] jaddr,
                                logic e_req, logic chk_addr, logic [31:0] e_addr, logic [31:0] e_inst,
                                logic [31:0] e_ipc, logic e_valid, logic e_fault);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = st; v.jmp = jmp; v.jaddr = jaddr;
        v.e_req = e_req; v.chk_addr = chk_addr; v.e_addr = e_addr; v.e_inst = e_inst;
        v.e_ipc = e_ipc; v.e_valid = e_valid; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_req, input logic chk_addr, input logic [31:0] e_addr,
                             input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_valid,
                             input logic e_fault);
        check("imem_req", idx, {31'd0, bus.imem_req}, {31'd0, e_req});
        if (chk_addr) check("imem_addr", idx, bus.imem_addr, e_addr);
        check("inst", idx, inst, e_inst);
        check("inst_pc", idx, inst_pc, e_ipc);
        check("inst_valid", idx, {31'd0, inst_valid}, {31'd0, e_valid});
        check("fetch_fault", idx, {31'd0, fetch_fault}, {31'd0, e_fault});
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic st, input logic jmp,
                         input logic [31:0] jaddr);
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        stall          = st;
        jmp_taken      = jmp;
        jmp_addr       = jaddr;
    endtask

    initial begin
        // ack  rdata         stall jmp jaddr         req chk addr          inst          ipc           v  f
        vecs[0]  = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h100, NOP,          32'h0,   0, 0); // BOOT->FETCH
        vecs[1]  = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h100, NOP,          32'h0,   0, 0); // wait for ack
        vecs[2]  = mk(1, 32'h00100093, 0, 0, 32'h0,   0, 1, 32'h104, 32'h00100093, 32'h100, 1, 0); // issue 0x100
        vecs[3]  = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h104, NOP,          32'h0,   0, 0); // NOP between
        vecs[4]  = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h104, NOP,          32'h0,   0, 0);
        vecs[5]  = mk(1, 32'h00500093, 0, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0); // issue 0x104
        vecs[6]  = mk(1, 32'hFFFFFFFF, 1, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0); // stall x5,
        vecs[7]  = mk(1, 32'hFFFFFFFF, 1, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0); // stray ack
        vecs[8]  = mk(1, 32'hFFFFFFFF, 1, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0); // ignored
        vecs[9]  = mk(0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0);
        vecs[10] = mk(0, 32'h0,        1, 0, 32'h0,   0, 1, 32'h108, 32'h00500093, 32'h104, 1, 0);
        vecs[11] = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h108, NOP,          32'h0,   0, 0); // FETCH@0x108
        vecs[12] = mk(0, 32'h0,        0, 1, 32'h200, 1, 1, 32'h108, NOP,          32'h0,   0, 0); // jump, no ack
        vecs[13] = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h108, NOP,          32'h0,   0, 0); // drain hold
        vecs[14] = mk(0, 32'h0,        0, 0, 32'h0,   1, 1, 32'h108, NOP,          32'h0,   0, 0);
        vecs[15] = mk(1, 32'hDEADBEEF, 0, 0, 32'h0,   1, 1, 32'h200, NOP,          32'h0,   0, 0); // dropped
        vecs[16] = mk(1, 32'h12345678, 0, 1, 32'h300, 1, 1, 32'h300, NOP,          32'h0,   0, 0); // jmp+ack
        vecs[17] = mk(1, 32'h00A00113, 0, 0, 32'h0,   0, 1, 32'h304, 32'h00A00113, 32'h300, 1, 0);
        vecs[18] = mk(0, 32'h0,        1, 1, 32'h400, 1, 1, 32'h400, NOP,          32'h0,   0, 0); // jmp beats stall
        vecs[19] = mk(0, 32'h0,        0, 1, 32'h202, 1, 1, 32'h400, NOP,          32'h0,   0, 1); // misaligned
        vecs[20] = mk(1, 32'h0BADF00D, 0, 0, 32'h0,   0, 0, 32'h0,   NOP,          32'h0,   0, 1); // -> HALT
        vecs[21] = mk(1, 32'h0BADF00D, 0, 1, 32'h500, 0, 0, 32'h0,   NOP,          32'h0,   0, 1); // jmp ignored
        vecs[22] = mk(1, 32'h0BADF00D, 0, 0, 32'h0,   0, 0, 32'h0,   NOP,          32'h0,   0, 1);

        nreset = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all(100, 0, 1, 32'h100, NOP, 32'h0, 0, 0);

        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].jmp, vecs[i].jaddr);
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_req, vecs[i].chk_addr, vecs[i].e_addr, vecs[i].e_inst,
                      vecs[i].e_ipc, vecs[i].e_valid, vecs[i].e_fault);
        end

        // Reset out of HALT clears the sticky fault
        #2 nreset = 1'b0;
        #1 check_all(200, 0, 1, 32'h100, NOP, 32'h0, 0, 0);
        @(negedge clk);
        nreset = 1'b1;
        drive(0, 32'h0, 0, 1, 32'h600);          // jump in BOOT is ignored
        @(posedge clk); #1;
        check_all(201, 1, 1, 32'h100, NOP, 32'h0, 0, 0);
        drive(1, 32'h00000093, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_all(202, 0, 1, 32'h104, 32'h00000093, 32'h100, 1, 0);
        drive(0, 32'h0, 0, 1, 32'h201);          // misaligned redirect from ISSUE
        @(posedge clk); #1;
        check_all(203, 0, 0, 32'h0, NOP, 32'h0, 0, 1);
        drive(1, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_all(204 + k, 0, 0, 32'h0, NOP, 32'h0, 0, 1);
        end

        // Async reset while a fetch is outstanding
        #2 nreset = 1'b0;
        #1 check_all(210, 0, 1, 32'h100, NOP, 32'h0, 0, 0);
        @(negedge clk);
        nreset = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_all(211, 1, 1, 32'h100, NOP, 32'h0, 0, 0);
        drive(1, 32'h00700093, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_all(212, 0, 1, 32'h104, 32'h00700093, 32'h100, 1, 0);
        drive(0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_all(213, 1, 1, 32'h104, NOP, 32'h0, 0, 0);
        #2 nreset = 1'b0;                        // mid-FETCH, well before the next edge
        #1 check_all(214, 0, 1, 32'h100, NOP, 32'h0, 0, 0);
        @(negedge clk);
        nreset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
